// File: rtl/fsm_multicycle_seq.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait timeout
// and illegal-opcode trap. Strobes are combinational from state and inputs.
module fsm_multicycle_seq #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [2:0]       step,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal,
  output logic             timeout
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;

  logic               mem_req_c, mem_we_c, mem_addr_sel_c, ir_write_c, pc_write_c;
  logic [1:0]         pc_src_c;
  logic               reg_write_c, reg_dst_c, mem_to_reg_c, instr_done_c;
  logic               op_legal;

  always_comb begin
    op_legal = (opcode == OP_ADD) || (opcode == OP_ADDI) || (opcode == OP_LW) ||
               (opcode == OP_SW)  || (opcode == OP_BEQ)  || (opcode == OP_J);
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = '0;
    illegal_d      = illegal_q;
    timeout_d      = timeout_q;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_write_c     = 1'b0;
    pc_write_c     = 1'b0;
    pc_src_c       = 2'b00;
    reg_write_c    = 1'b0;
    reg_dst_c      = 1'b0;
    mem_to_reg_c   = 1'b0;
    instr_done_c   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = S_ERR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_ERR;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_BEQ: begin
            pc_write_c   = zero;
            pc_src_c     = 2'b01;
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
          end
          OP_J: begin
            pc_write_c   = 1'b1;
            pc_src_c     = 2'b10;
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
          end
          OP_ADD, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:    state_d = S_MEM;
          default: begin
            state_d   = S_ERR;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
          end else if (opcode == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d   = S_ERR;
            illegal_d = 1'b1;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = S_ERR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = (opcode == OP_ADD);
        mem_to_reg_c = (opcode == OP_LW);
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    instr_cnt_d = instr_done_c ? instr_cnt_q + 1'b1 : instr_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      instr_cnt_q <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
    end
  end

  // Strobes are gated by rst directly so they drop the moment reset rises.
  always_comb begin
    mem_req      = mem_req_c      & ~rst;
    mem_we       = mem_we_c       & ~rst;
    mem_addr_sel = mem_addr_sel_c & ~rst;
    ir_write     = ir_write_c     & ~rst;
    pc_write     = pc_write_c     & ~rst;
    pc_src       = rst ? 2'b00 : pc_src_c;
    reg_write    = reg_write_c    & ~rst;
    reg_dst      = reg_dst_c      & ~rst;
    mem_to_reg   = mem_to_reg_c   & ~rst;
    instr_done   = instr_done_c   & ~rst;
  end

  assign step      = state_q;
  assign instr_cnt = instr_cnt_q;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;

endmodule
